// File: rtl/descriptor_word_server.sv
// Descriptor word store: host fills a RAM sequentially, the matcher streams it back with a
// level read strobe and rewind. Define DESC_SERVER_WRAP_EN to loop the read pointer at end of data.
module descriptor_word_server #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 12,
  parameter int WORDS_PER_DESC = 64
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iWrClear,
  input  logic              iWrEn,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iRead,
  input  logic              iRewind,
  output logic [DATA_W-1:0] oData,
  output logic              oDataValid,
  output logic [ADDR_W:0]   oWordCount,
  output logic [ADDR_W:0]   oDescCount,
  output logic              oFull,
  output logic              oOverflow,
  output logic              oUnderflow
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam int              DESC_SHIFT = $clog2(WORDS_PER_DESC);
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ramQ;
  logic [ADDR_W:0]   wrPtr;
  logic [ADDR_W:0]   rdPtr;
  logic [ADDR_W:0]   rdPtrNext;
  logic              dataZero;
  logic              dataValid;
  logic              overflow;
  logic              underflow;
  logic              full;
  logic              wrAccept;
  logic              wrReject;
  logic              readHit;
  logic              readMiss;

  // The write pointer doubles as the stored-word count.
  assign full = (wrPtr == FULL_COUNT);

  // NOTE: every output of a combinational block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    wrAccept  = 1'b0;
    wrReject  = 1'b0;
    readHit   = 1'b0;
    readMiss  = 1'b0;
    rdPtrNext = rdPtr;

    if (!iWrClear && iWrEn) begin
      wrAccept = !full;
      wrReject = full;
    end

    // Rewind wins over a read in the same cycle; the range check uses the pre-write count.
    if (iRewind) begin
      rdPtrNext = '0;
    end else if (iRead) begin
`ifdef DESC_SERVER_WRAP_EN
      if (wrPtr == '0) begin
        readMiss = 1'b1;
      end else if (rdPtr < wrPtr) begin
        readHit   = 1'b1;
        rdPtrNext = (rdPtr == wrPtr - PTR_ONE) ? '0 : rdPtr + PTR_ONE;
      end else begin
        // Pointer left beyond the data by a host clear: restart the loop without a word.
        rdPtrNext = '0;
      end
`else
      if (rdPtr < wrPtr) begin
        readHit   = 1'b1;
        rdPtrNext = rdPtr + PTR_ONE;
      end else begin
        readMiss = 1'b1;
      end
`endif
    end
  end

  // NOTE: the RAM array and its read register carry no reset, so they map onto block RAM;
  // the consumer-visible state is masked by the reset control registers below instead.
  always_ff @(posedge iClk) begin
    if (wrAccept) begin
      mem[wrPtr[ADDR_W-1:0]] <= iWrData;
    end
  end

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge iClk) begin
    if (readHit) begin
      ramQ <= mem[rdPtr[ADDR_W-1:0]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      dataZero  <= 1'b1;
      dataValid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rdPtr     <= rdPtrNext;
      dataValid <= readHit;

      if (readHit) begin
        dataZero <= 1'b0;
      end else if (readMiss) begin
        dataZero <= 1'b1;
      end

      if (iWrClear) begin
        wrPtr     <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wrAccept) begin
          wrPtr <= wrPtr + PTR_ONE;
        end
        if (wrReject) begin
          overflow <= 1'b1;
        end
        if (readMiss) begin
          underflow <= 1'b1;
        end
      end
    end
  end

  // oData holds the last word while idle and reads as zero after reset or an underflow.
  assign oData      = dataZero ? '0 : ramQ;
  assign oDataValid = dataValid;
  assign oWordCount = wrPtr;
  assign oDescCount = wrPtr >> DESC_SHIFT;
  assign oFull      = full;
  assign oOverflow  = overflow;
  assign oUnderflow = underflow;

endmodule

// File: tb/tb_descriptor_word_server.sv
// Self-checking bench for descriptor_word_server: a default-size instance checked against an
// array/queue reference model, plus a 16-word instance for the full/overflow boundary.
module tb_descriptor_word_server;

  localparam int DEPTH = 4096;
  localparam int WPD   = 64;

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic        iWrClear = 1'b0, iWrEn = 1'b0, iRead = 1'b0, iRewind = 1'b0;
  logic [15:0] iWrData = '0;
  logic [15:0] oData;
  logic        oDataValid, oFull, oOverflow, oUnderflow;
  logic [12:0] oWordCount, oDescCount;

  logic        sWrClear = 1'b0, sWrEn = 1'b0, sRead = 1'b0, sRewind = 1'b0;
  logic [15:0] sWrData = '0;
  logic [15:0] sData;
  logic        sValid, sFull, sOvf, sUnf;
  logic [4:0]  sCount, sDesc;

  int nChecks = 0;
  int nFail   = 0;

  always #5 iClk = ~iClk;

  descriptor_word_server dut (
    .iClk(iClk), .iReset(iReset), .iWrClear(iWrClear), .iWrEn(iWrEn), .iWrData(iWrData),
    .iRead(iRead), .iRewind(iRewind), .oData(oData), .oDataValid(oDataValid),
    .oWordCount(oWordCount), .oDescCount(oDescCount), .oFull(oFull),
    .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  descriptor_word_server #(.DATA_W(16), .ADDR_W(4), .WORDS_PER_DESC(4)) dutSmall (
    .iClk(iClk), .iReset(iReset), .iWrClear(sWrClear), .iWrEn(sWrEn), .iWrData(sWrData),
    .iRead(sRead), .iRewind(sRewind), .oData(sData), .oDataValid(sValid),
    .oWordCount(sCount), .oDescCount(sDesc), .oFull(sFull),
    .oOverflow(sOvf), .oUnderflow(sUnf)
  );

  // Reference model of the default instance: stored words, read index and flags.
  bit [15:0] mMem [DEPTH];
  int        mCount, mRptr;
  bit [15:0] mData;
  bit        mValid, mOvf, mUnf;

  function automatic void modelReset();
    mCount = 0; mRptr = 0; mData = '0; mValid = 0; mOvf = 0; mUnf = 0;
  endfunction

  function automatic void modelStep();
    int oldCount = mCount;
    mValid = 0;
    if (iRewind) begin
      mRptr = 0;
    end else if (iRead) begin
`ifdef DESC_SERVER_WRAP_EN
      if (oldCount == 0) mUnf = 1;
      else if (mRptr < oldCount) begin
        mData = mMem[mRptr]; mValid = 1; mRptr = (mRptr + 1) % oldCount;
      end else mRptr = 0;
`else
      if (mRptr < oldCount) begin
        mData = mMem[mRptr]; mValid = 1; mRptr++;
      end else begin
        mData = '0; mUnf = 1;
      end
`endif
    end
    if (iWrClear) begin
      mCount = 0; mOvf = 0; mUnf = 0;
    end else if (iWrEn) begin
      if (mCount == DEPTH) mOvf = 1;
      else begin
        mMem[mCount] = iWrData; mCount++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge iClk);
    modelStep();
    #1;
  endtask

  task automatic loadWords(input int n, input bit ramp);
    iWrEn = 1'b1;
    for (int i = 0; i < n; i++) begin
      iWrData = ramp ? 16'(i) : 16'($urandom);
      tick();
    end
    iWrEn = 1'b0;
  endtask

  task automatic clearAndRewind();
    iWrClear = 1'b1; iRewind = 1'b1;
    tick();
    iWrClear = 1'b0; iRewind = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    modelReset();
    nChecks++; if (oData !== 16'h0) begin nFail++; $display("FAIL reset_data: got %h want 0000", oData); end
    nChecks++; if (oDataValid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", oDataValid); end
    nChecks++; if (oWordCount !== 13'd0) begin nFail++; $display("FAIL reset_count: got %0d want 0", oWordCount); end
    nChecks++; if ({oFull, oOverflow, oUnderflow} !== 3'b000) begin nFail++; $display("FAIL reset_flags: got %b want 000", {oFull, oOverflow, oUnderflow}); end
    nChecks++; if (sCount !== 5'd0 || sFull !== 1'b0) begin nFail++; $display("FAIL reset_small: count %0d full %b want 0 0", sCount, sFull); end
    iReset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    loadWords(128, 1'b1);
    nChecks++; if (oWordCount !== 13'd128) begin nFail++; $display("FAIL stream_count: got %0d want 128", oWordCount); end
    nChecks++; if (oDescCount !== 13'd2) begin nFail++; $display("FAIL stream_desc: got %0d want 2", oDescCount); end
    iRead = 1'b1;
    for (int i = 0; i < 128; i++) begin
      tick();
      nChecks++; if (oData !== 16'(i) || oDataValid !== 1'b1) begin nFail++; $display("FAIL stream_word%0d: got %h/%b want %h/1", i, oData, oDataValid, 16'(i)); end
    end
    iRead = 1'b0;
    tick();
    nChecks++; if (oData !== 16'h007F || oDataValid !== 1'b0) begin nFail++; $display("FAIL stream_hold: got %h/%b want 007f/0", oData, oDataValid); end
  endtask

  task automatic test_rewind();
    iRewind = 1'b1; tick(); iRewind = 1'b0;
    iRead = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      nChecks++; if (oData !== 16'(i) || oDataValid !== 1'b1) begin nFail++; $display("FAIL rewind_word%0d: got %h/%b want %h/1", i, oData, oDataValid, 16'(i)); end
    end
    iRead = 1'b0; iRewind = 1'b1; tick();
    iRewind = 1'b0; iRead = 1'b1; tick();
    nChecks++; if (oData !== 16'h0000 || oDataValid !== 1'b1) begin nFail++; $display("FAIL rewind_first: got %h/%b want 0000/1", oData, oDataValid); end
    tick();
    iRewind = 1'b1; tick();
    nChecks++; if (oDataValid !== 1'b0) begin nFail++; $display("FAIL rewind_beats_read: valid %b want 0", oDataValid); end
    iRewind = 1'b0; tick();
    nChecks++; if (oData !== 16'h0000 || oDataValid !== 1'b1) begin nFail++; $display("FAIL rewind_ptr_zero: got %h/%b want 0000/1", oData, oDataValid); end
    iRead = 1'b0; tick();
  endtask

  task automatic test_underflow();
    bit [15:0] w [3];
    clearAndRewind();
    iWrEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w[i] = 16'($urandom_range(1, 16'hFFFF));
      iWrData = w[i];
      tick();
    end
    iWrEn = 1'b0;
    iRead = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bit [15:0] expData;
      bit        expValid;
`ifdef DESC_SERVER_WRAP_EN
      expData = w[k % 3]; expValid = 1'b1;
`else
      expData = (k < 3) ? w[k] : 16'h0; expValid = (k < 3);
`endif
      tick();
      nChecks++; if (oData !== expData || oDataValid !== expValid) begin nFail++; $display("FAIL underflow_rd%0d: got %h/%b want %h/%b", k, oData, oDataValid, expData, expValid); end
    end
    iRead = 1'b0;
    tick();
    nChecks++; if (oUnderflow !== 1'(mUnf)) begin nFail++; $display("FAIL underflow_sticky: got %b want %b", oUnderflow, mUnf); end
    iWrClear = 1'b1; tick(); iWrClear = 1'b0;
    nChecks++; if (oUnderflow !== 1'b0 || oWordCount !== 13'd0) begin nFail++; $display("FAIL underflow_clear: flag %b count %0d want 0 0", oUnderflow, oWordCount); end
  endtask

  task automatic test_overflow();
    sWrEn = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      sWrData = 16'(i - 1) ^ 16'hA500;
      tick();
      if (i == 15) begin
        nChecks++; if (sFull !== 1'b0) begin nFail++; $display("FAIL ovf_full_early: got %b want 0", sFull); end
      end
      if (i == 16) begin
        nChecks++; if (sFull !== 1'b1 || sCount !== 5'd16 || sOvf !== 1'b0) begin nFail++; $display("FAIL ovf_full: full %b count %0d ovf %b want 1 16 0", sFull, sCount, sOvf); end
      end
      if (i == 17) begin
        nChecks++; if (sOvf !== 1'b1 || sCount !== 5'd16) begin nFail++; $display("FAIL ovf_flag: ovf %b count %0d want 1 16", sOvf, sCount); end
      end
    end
    sWrEn = 1'b0;
    nChecks++; if (sDesc !== 5'd4) begin nFail++; $display("FAIL ovf_desc: got %0d want 4", sDesc); end
    sRead = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      nChecks++; if (sData !== (16'(i) ^ 16'hA500) || sValid !== 1'b1) begin nFail++; $display("FAIL ovf_read%0d: got %h/%b want %h/1", i, sData, sValid, 16'(i) ^ 16'hA500); end
    end
    sRead = 1'b0;
    sWrClear = 1'b1; tick(); sWrClear = 1'b0;
    nChecks++; if (sCount !== 5'd0 || sFull !== 1'b0 || sOvf !== 1'b0) begin nFail++; $display("FAIL ovf_clear: count %0d full %b ovf %b want 0 0 0", sCount, sFull, sOvf); end
  endtask

  task automatic test_same_cycle();
    bit [15:0] newWord;
    clearAndRewind();
    loadWords(64, 1'b0);
    iRead = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      nChecks++; if (oData !== mData || oDataValid !== 1'b1) begin nFail++; $display("FAIL same_pre%0d: got %h/%b want %h/1", i, oData, oDataValid, mData); end
    end
    newWord = 16'($urandom_range(1, 16'hFFFF));
    iWrEn = 1'b1; iWrData = newWord;
    tick();
    iWrEn = 1'b0;
    nChecks++; if (oDataValid !== 1'b0 || oData !== 16'h0 || oUnderflow !== 1'b1) begin nFail++; $display("FAIL same_cycle_rd: got %h/%b unf %b want 0000/0 1", oData, oDataValid, oUnderflow); end
    nChecks++; if (oWordCount !== 13'd65 || oDescCount !== 13'd1) begin nFail++; $display("FAIL same_cycle_cnt: count %0d desc %0d want 65 1", oWordCount, oDescCount); end
    tick();
    nChecks++; if (oData !== newWord || oDataValid !== 1'b1) begin nFail++; $display("FAIL same_next_rd: got %h/%b want %h/1", oData, oDataValid, newWord); end
    iRead = 1'b0; tick();
  endtask

  task automatic test_reset_midstream();
    clearAndRewind();
    loadWords(128, 1'b1);
    iRead = 1'b1;
    repeat (20) tick();
    #2 iReset = 1'b1;
    #1;
    modelReset();
    nChecks++; if (oDataValid !== 1'b0 || oData !== 16'h0) begin nFail++; $display("FAIL midreset_data: got %h/%b want 0000/0", oData, oDataValid); end
    nChecks++; if (oWordCount !== 13'd0 || oDescCount !== 13'd0) begin nFail++; $display("FAIL midreset_count: got %0d/%0d want 0/0", oWordCount, oDescCount); end
    nChecks++; if ({oFull, oOverflow, oUnderflow} !== 3'b000) begin nFail++; $display("FAIL midreset_flags: got %b want 000", {oFull, oOverflow, oUnderflow}); end
    iRead = 1'b0;
    @(posedge iClk);
    #3 iReset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    clearAndRewind();
    for (int c = 0; c < 600; c++) begin
      iWrEn    = ($urandom_range(0, 2) == 0);
      iWrData  = 16'($urandom);
      iRead    = ($urandom_range(0, 1) == 1);
      iRewind  = ($urandom_range(0, 15) == 0);
      iWrClear = ($urandom_range(0, 99) == 0);
      tick();
      nChecks++; if (oDataValid !== 1'(mValid) || oData !== mData) begin nFail++; $display("FAIL rand_data c%0d: got %h/%b want %h/%b", c, oData, oDataValid, mData, mValid); end
      nChecks++; if (oWordCount !== 13'(mCount) || oDescCount !== 13'(mCount / WPD)) begin nFail++; $display("FAIL rand_count c%0d: got %0d/%0d want %0d/%0d", c, oWordCount, oDescCount, mCount, mCount / WPD); end
      nChecks++; if (oFull !== (mCount == DEPTH) || oOverflow !== 1'(mOvf) || oUnderflow !== 1'(mUnf)) begin nFail++; $display("FAIL rand_flags c%0d: got %b%b%b want %b%b%b", c, oFull, oOverflow, oUnderflow, mCount == DEPTH, mOvf, mUnf); end
    end
    {iWrEn, iRead, iRewind, iWrClear} = '0;
    tick();
  endtask

  initial begin
    modelReset();
    test_reset();
    test_stream();
    test_rewind();
    test_underflow();
    test_overflow();
    test_same_cycle();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
